dad16seq: RTL and testbench
===========================

# dad16seq

16-bit register-pair arithmetic sequencer for the 8085 core. It runs DAD, INX and DCX by driving the shared 8-bit add/sub unit over two cycles, low byte first and then high byte. The high byte is chained with the low-byte carry through the adder's carry-select input. It sits directly upstream of the 8-bit adder. It collects the 16-bit result and the DAD carry for the register file and the flag register.

## Interface
Parameters: none.

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- go  in  1  start request; accepted only when busy=0
- op  in  2  operation: 00 DAD (X+Y), 01 INX (X+1), 10 DCX (X-1), 11 reserved
- opX  in  16  HL for DAD, register pair for INX/DCX
- opY  in  16  register pair for DAD; ignored otherwise
- adA  out  8  adder operand A
- adB  out  8  adder operand B
- adC  out  1  adder carry input
- adOp  out  3  adder op select: bit2 = 0, bit1 = 0 (always ADD), bit0 = carry-select
- adS  in  8  adder sum, combinational from adA/adB/adC/adOp
- adCY  in  2  adder carries: bit1 = AC (ignored), bit0 = CY
- res  out  16  result; valid from the done cycle until the next accepted go
- cyOut  out  1  DAD carry out of bit 15
- cyWr  out  1  one-cycle flag write strobe for CY; DAD only
- done  out  1  one-cycle completion pulse
- busy  out  1  high in LO and HI states

## Operation
- FSM states: IDLE, LO, HI, FIN.
- IDLE/FIN + go=1:
  - latch opX into xr and op into opr.
  - latch yr: opY for DAD, 0x0001 for INX, 0xFFFF for DCX.
  - go to LO; op 11 goes to FIN instead.
- LO:
  - adA=xr[7:0], adB=yr[7:0], adC=0, adOp=000.
  - capture res[7:0]<=adS and cr<=adCY[0].
  - go to HI.
- HI:
  - adA=xr[15:8], adB=yr[15:8], adC=cr, adOp=001.
  - capture res[15:8]<=adS and c16<=adCY[0].
  - go to FIN.
- FIN:
  - done=1.
  - cyWr=1 and cyOut=c16 if opr=DAD; otherwise cyWr=0 and cyOut holds its previous value.
  - next state is LO if go is accepted, else IDLE.
- DCX is performed as X+0xFFFF so the adder only ever adds. The adder's subtract path is never used.
- Reserved op 11: res<=opX at acceptance, FIN next cycle with done=1 and cyWr=0.
- In IDLE and FIN, adA, adB, adC and adOp are all 0.
- Width rules:
  - bit-16 carry goes only to cyOut, and only for DAD.
  - INX 0xFFFF wraps to 0x0000; DCX 0x0000 wraps to 0xFFFF; no flags change in either case.
- go while busy=1 is ignored, with no queueing. The latched operands are unaffected by later changes on opX, opY and op.
- AC (adCY[1]) is ignored in both cycles.

## Timing
- go sampled high in cycle n:
  - LO in n+1.
  - HI in n+2.
  - FIN in n+3, with done=1, res valid and cyWr as above.
- Reserved op: FIN in n+1.
- Throughput: go asserted in the FIN cycle is accepted, giving back-to-back operations every 3 cycles.
- The adder is combinational. adS/adCY are sampled at the end of the same cycle the operands are driven.
- Reset (rst_n=0 at an edge), applied in any state:
  - state=IDLE.
  - res=0, cyOut=0, cyWr=0, done=0, busy=0.
  - adA/adB/adC/adOp=0.
  - xr, yr, cr, c16 and opr cleared.
- Reset mid-operation aborts with no done and no cyWr. The first go after release is accepted normally.

## Structure
- Shared core package holds:
  - op encodings (OP_DAD, OP_INX, OP_DCX, OP_RSV).
  - FSM state encoding.
  - adder selOp constants: SEL_ADD=000, SEL_ADC=001.
- Single module. There is no natural sub-module: the 8-bit adder is the existing shared unit, instantiated at the core level and connected through the ad* ports.

## Test plan
Bench includes a behavioural model of the 8-bit adder:
- carry-in = ~adOp[2] & adOp[0] & adC.
- CY = bit 8 of the sum; AC = carry out of bit 3.

Scenarios:
- DAD X=0x12FF, Y=0x0001 -> at n+3: res=0x1300, cyOut=0, cyWr=1, done=1; adOp=001 and adC=1 during HI.
- DAD X=0xFFFF, Y=0x0001 -> res=0x0000, cyOut=1, cyWr=1; DAD X=0x8000, Y=0x8000 -> res=0x0000, cyOut=1.
- INX X=0x00FF -> res=0x0100, cyWr=0, cyOut unchanged; DCX X=0x0000 -> res=0xFFFF, cyWr=0; INX X=0xFFFF -> res=0x0000, cyWr=0.
- go held high continuously with changing operands -> an op accepted every 3 cycles; go in LO/HI ignored; the result reflects operands latched at acceptance.
- rst_n=0 during HI of a DAD -> next cycle all outputs 0 and state IDLE; no done or cyWr ever appears for the aborted op.
- op=11, X=0xABCD -> done at n+1, res=0xABCD, cyWr=0, adder inputs stay 0.

Source files
------------

// File: rtl/dad16seq_pkg.sv
// dad16seq_pkg: op, state and adder-select encodings shared with the 8085 core.
package dad16seq_pkg;
   typedef enum logic [1:0] {OP_DAD = 2'b00, OP_INX = 2'b01, OP_DCX = 2'b10, OP_RSV = 2'b11} opT;
   typedef enum logic [1:0] {IDLE = 2'b00, LO = 2'b01, HI = 2'b10, FIN = 2'b11} stateT;
   localparam logic [2:0] SEL_ADD = 3'b000;
   localparam logic [2:0] SEL_ADC = 3'b001;
endpackage

// File: rtl/dad16seq.sv
// dad16seq: two-cycle 16-bit DAD/INX/DCX sequencer driving the shared 8-bit adder.
module dad16seq
   import dad16seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [1:0]  op,
   input  logic [15:0] opX,
   input  logic [15:0] opY,
   output logic [7:0]  adA,
   output logic [7:0]  adB,
   output logic        adC,
   output logic [2:0]  adOp,
   input  logic [7:0]  adS,
   input  logic [1:0]  adCY,
   output logic [15:0] res,
   output logic        cyOut,
   output logic        cyWr,
   output logic        done,
   output logic        busy
);
   stateT state, nextState;
   opT opr;
   logic [15:0] xr, yr;
   logic cr, accept, unusedAc;
   assign unusedAc = adCY[1];
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= nextState;
   end
   always_comb begin
      busy = (state == LO) || (state == HI);
      accept = go && !busy;
      done = state == FIN;
      cyWr = done && opr == OP_DAD;
      adA = state == LO ? xr[7:0] : state == HI ? xr[15:8] : 8'h00;
      adB = state == LO ? yr[7:0] : state == HI ? yr[15:8] : 8'h00;
      adC = state == HI && cr;
      adOp = state == HI ? SEL_ADC : SEL_ADD;
      nextState = accept ? (op == OP_RSV ? FIN : LO) : state == LO ? HI : state == HI ? FIN : IDLE;
   end
   // DCX adds 0xFFFF so the adder never needs its subtract path
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xr <= '0;
         yr <= '0;
         cr <= 1'b0;
         opr <= OP_DAD;
         res <= '0;
         cyOut <= 1'b0;
      end else if (accept) begin
         xr <= opX;
         opr <= opT'(op);
         yr <= op == OP_DAD ? opY : op == OP_INX ? 16'h0001 : 16'hFFFF;
         if (op == OP_RSV) res <= opX;
      end else if (state == LO) begin
         res[7:0] <= adS;
         cr <= adCY[0];
      end else if (state == HI) begin
         res[15:8] <= adS;
         if (opr == OP_DAD) cyOut <= adCY[0];
      end
   end
endmodule

// File: tb/tb_dad16seq.sv
// tb_dad16seq: table-driven and hand-sequenced checks of dad16seq against a behavioural 8-bit adder.
module tb_dad16seq;
   logic clk = 1'b0, rst_n = 1'b0, go = 1'b0;
   logic [1:0] op = 2'b00;
   logic [15:0] opX = '0, opY = '0, res;
   logic [7:0] adA, adB, adS;
   logic adC, cyOut, cyWr, done, busy, cin;
   logic [2:0] adOp;
   logic [1:0] adCY;
   logic [8:0] sum9;
   logic [4:0] nib;
   int compared = 0, mismatched = 0;

   typedef struct {
      logic [1:0] op;
      logic [15:0] x, y, res;
      logic cy, wr;
      int lat;
   } vecT;
   vecT vecs[10];
   vecT sb[$];

   dad16seq dut (.clk(clk), .rst_n(rst_n), .go(go), .op(op), .opX(opX), .opY(opY),
      .adA(adA), .adB(adB), .adC(adC), .adOp(adOp), .adS(adS), .adCY(adCY),
      .res(res), .cyOut(cyOut), .cyWr(cyWr), .done(done), .busy(busy));

   always #5 clk = ~clk;

   assign cin = ~adOp[2] & adOp[0] & adC;
   assign sum9 = {1'b0, adA} + {1'b0, adB} + {8'h00, cin};
   assign nib = {1'b0, adA[3:0]} + {1'b0, adB[3:0]} + {4'h0, cin};
   assign adS = sum9[7:0];
   assign adCY = {nib[4], sum9[8]};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, " res"}, 32'(res), 32'h0);
      check({tag, " cyOut"}, 32'(cyOut), 32'h0);
      check({tag, " cyWr"}, 32'(cyWr), 32'h0);
      check({tag, " done"}, 32'(done), 32'h0);
      check({tag, " busy"}, 32'(busy), 32'h0);
      check({tag, " adder inputs"}, {19'h0, adA, adB, adC, adOp}, 32'h0);
   endtask

   task automatic runOp(input vecT v);
      vecT e;
      int k;
      sb.push_back(v);
      go = 1'b1; op = v.op; opX = v.x; opY = v.y;
      tick;
      go = 1'b0; op = 2'($urandom); opX = 16'($urandom); opY = 16'($urandom);
      k = 1;
      while (!done && k < 8) begin
         tick;
         k++;
      end
      e = sb.pop_front();
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL timeout: no done after %0d cycles, expected done at %0d", k, e.lat);
      end else begin
         check("latency", 32'(k), 32'(e.lat));
         check("res", 32'(res), 32'(e.res));
         check("cyOut", 32'(cyOut), 32'(e.cy));
         check("cyWr", 32'(cyWr), 32'(e.wr));
         check("adder inputs in FIN", {19'h0, adA, adB, adC, adOp}, 32'h0);
      end
   endtask

   initial begin
      vecs[0] = '{2'b00, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b1, 3};
      vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 3};
      vecs[2] = '{2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 3};
      vecs[3] = '{2'b01, 16'h00FF, 16'h5A5A, 16'h0100, 1'b1, 1'b0, 3};
      vecs[4] = '{2'b10, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 3};
      vecs[5] = '{2'b01, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 3};
      vecs[6] = '{2'b00, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b1, 3};
      vecs[7] = '{2'b10, 16'h1000, 16'hFFFF, 16'h0FFF, 1'b0, 1'b0, 3};
      vecs[8] = '{2'b11, 16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b0, 1};
      vecs[9] = '{2'b00, 16'h0F0F, 16'hF0F1, 16'h0000, 1'b1, 1'b1, 3};

      tick;
      tick;
      checkIdleOutputs("reset");
      rst_n = 1'b1;
      tick;

      // DAD 0x12FF + 0x0001: low-byte carry must chain into HI via adC/adOp
      go = 1'b1; op = 2'b00; opX = 16'h12FF; opY = 16'h0001;
      tick;
      go = 1'b0;
      check("LO adA/adB", {16'h0, adA, adB}, 32'h0000FF01);
      check("LO adC/adOp", {28'h0, adC, adOp}, 32'h0);
      check("LO busy/done", {30'h0, busy, done}, 32'h2);
      tick;
      check("HI adA/adB", {16'h0, adA, adB}, 32'h00001200);
      check("HI adC/adOp", {28'h0, adC, adOp}, 32'h9);
      tick;
      check("FIN done/busy", {30'h0, done, busy}, 32'h2);
      check("FIN res", 32'(res), 32'h1300);
      check("FIN cyWr/cyOut", {30'h0, cyWr, cyOut}, 32'h2);
      tick;
      check("post-FIN strobes", {29'h0, done, cyWr, busy}, 32'h0);
      check("post-FIN res held", 32'(res), 32'h1300);

      for (int i = 0; i < 10; i++) runOp(vecs[i]);
      tick;

      // go held high: operands changed in LO/HI must be ignored
      go = 1'b1; op = 2'b00; opX = 16'h0101; opY = 16'h0202;
      tick;
      check("b2b LO1 busy/done", {30'h0, busy, done}, 32'h2);
      op = 2'b10; opX = 16'h5555; opY = 16'h1111;
      tick;
      check("b2b HI1 done", 32'(done), 32'h0);
      op = 2'b01; opX = 16'h7777; opY = 16'h9999;
      tick;
      check("b2b FIN1 done", 32'(done), 32'h1);
      check("b2b FIN1 res", 32'(res), 32'h0303);
      check("b2b FIN1 cyWr/cyOut", {30'h0, cyWr, cyOut}, 32'h2);
      tick;
      check("b2b LO2 busy", 32'(busy), 32'h1);
      op = 2'b00; opX = 16'hAAAA; opY = 16'h6666;
      tick;
      opX = 16'h1111;
      tick;
      check("b2b FIN2 done", 32'(done), 32'h1);
      check("b2b FIN2 res", 32'(res), 32'h7778);
      check("b2b FIN2 cyWr/cyOut", {30'h0, cyWr, cyOut}, 32'h0);
      go = 1'b0;
      tick;

      // reset during HI of a carrying DAD aborts it with no strobes
      go = 1'b1; op = 2'b00; opX = 16'hFFFF; opY = 16'h0001;
      tick;
      go = 1'b0;
      tick;
      check("abort HI adC", 32'(adC), 32'h1);
      rst_n = 1'b0;
      tick;
      checkIdleOutputs("abort");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("abort no strobe", {30'h0, done, cyWr}, 32'h0);
      end
      runOp('{2'b01, 16'h0010, 16'h0000, 16'h0011, 1'b0, 1'b0, 3});
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
